csr_trap_unit: RTL and testbench
================================

Name: csr_trap_unit

Overview:
Parametrised machine-mode CSR file with full trap sequencing, for the next-generation ysyx_23060025 core.
- Adds CSRRW/CSRRS/CSRRC semantics and read-only/illegal-access detection.
- Adds mstatus MIE/MPIE stacking, mie/mip interrupt gating and vectored mtvec.
- Adds 64-bit mcycle/minstret counters.
- Sits beside the EXU/WBU: it takes CSR instructions, exceptions and mret, and returns a registered PC redirect to the IFU.

Parameters:
- DATA_WIDTH, 32, CSR/datapath width (32 only; counters split into low/high halves)
- MVENDORID_VAL, 32'h79737978, value of mvendorid
- MARCHID_VAL, 32'd23060025, value of marchid
- MTVEC_RESET, 32'h0, reset value of mtvec
- HAS_COUNTERS, 1, 1 = mcycle/minstret implemented; 0 = those addresses are illegal

Ports:
- clock  in  1  system clock
- reset  in  1  reset
- csr_valid_i  in  1  CSR instruction access this cycle
- csr_op_i  in  2  00 = none, 01 = RW, 10 = RS, 11 = RC
- csr_addr_i  in  12  CSR address
- csr_wdata_i  in  DATA_WIDTH  rs1 value or zero-extended uimm
- csr_rdata_o  out  DATA_WIDTH  old CSR value (combinational)
- csr_illegal_o  out  1  access is illegal (combinational)
- trap_valid_i  in  1  take exception or interrupt this cycle
- trap_cause_i  in  DATA_WIDTH  mcause value (bit 31 = interrupt)
- trap_pc_i  in  DATA_WIDTH  PC saved to mepc
- trap_tval_i  in  DATA_WIDTH  value saved to mtval
- mret_i  in  1  mret retiring
- instret_i  in  1  one instruction retired
- irq_timer_i  in  1  timer interrupt level, drives mip.MTIP
- irq_ext_i  in  1  external interrupt level, drives mip.MEIP
- irq_pending_o  out  1  enabled interrupt pending
- redirect_valid_o  out  1  one-cycle pulse: fetch from redirect_pc_o
- redirect_pc_o  out  DATA_WIDTH  trap/return target, held until next redirect

Behaviour:
Clocking and reset
- Reset is synchronous, active-high, on reset; all state changes on posedge clock.
- Reset values: mstatus = 32'h1800 (MPP = 11, MIE = 0, MPIE = 0); mtvec = MTVEC_RESET; mepc, mcause, mtval, mscratch, mie = 0; counters = 0.
- Output reset values: redirect_valid_o = 0, redirect_pc_o = 0.

Implemented CSRs and access rules
- mstatus 0x300: only MIE (bit 3), MPIE (bit 7) and MPP (bits 12:11) are writable; MPP reads 11 always; other bits read 0.
- mie 0x304: only bits 7 and 11 are writable.
- mtvec 0x305: bits 1:0 = mode (00 direct, 01 vectored); a write with mode 1x stores mode 00.
- mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343.
- mip 0x344: read-only, {MEIP bit 11, MTIP bit 7}, sampled from the inputs.
- mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82: read-write.
- mvendorid 0xF11, marchid 0xF12: read-only.

CSR access
- Read: csr_rdata_o = current value in the same cycle; an unknown address reads 0.
- New value: RW = wdata; RS = old | wdata; RC = old & ~wdata. Commits at the next edge when csr_valid_i is high and not illegal.
- csr_illegal_o = csr_valid_i & (unknown address | (write to a read-only CSR)).
- RS/RC with wdata == 0 is a read only: never illegal, writes nothing.
- Illegal accesses change no state; the pipeline raises the exception (cause 2).

Priority within one cycle: reset > trap_valid_i > mret_i > CSR write.
- A CSR write in the same cycle as a trap or mret is dropped.

Trap entry (trap_valid_i)
- mepc = trap_pc_i with bits 1:0 cleared; mcause = trap_cause_i; mtval = trap_tval_i.
- MPIE = MIE, MIE = 0.
- Next cycle: redirect_valid_o = 1 and redirect_pc_o = target.
- Target = {mtvec[31:2], 2'b00}, plus 4*cause[30:0] when mode = vectored and cause[31] = 1.

mret
- MIE = MPIE, MPIE = 1.
- Next cycle: redirect_valid_o = 1, redirect_pc_o = mepc. A same-cycle mepc write is dropped, so the pre-existing mepc is used.

Counters
- mcycle increments every cycle; minstret increments when instret_i = 1. Both are 64-bit and wrap silently at 2^64 − 1 → 0.
- A CSR write to either half overrides that cycle's increment for the whole 64-bit counter: the written half takes wdata, the other half holds.

Interrupts
- irq_pending_o = MIE & |(mie & mip), combinational.
- Prioritisation between interrupts and exceptions, and formation of the cause, is done upstream.

Decomposition:
- Shared package/define file:
  - CSR address constants
  - csr_op encodings
  - mstatus bit positions (MIE 3, MPIE 7, MPP 12:11)
  - mip/mie bit positions (7, 11)
  - cause codes (2 illegal, 11 ecall-M, 0x80000007 timer, 0x8000000B external)
- One sub-module: csr_counter64, a 64-bit counter with increment enable and per-half write enable; instantiated twice.

Test Plan:
1. Reset, then read 0x300, 0xF11, 0xF12 -> 32'h1800, 32'h79737978, 32'd23060025; redirect_valid_o = 0.
2. RW mtvec = 32'h8000_0101, then trap cause 32'h8000_0007 at pc 32'h8000_0040 -> next cycle redirect_pc_o = 32'h8000_011C, pulse high for 1 cycle; mepc = 32'h8000_0040, mcause = 32'h8000_0007.
3. Set MIE = 1 via RS 0x300 with wdata 8, trap, then mret -> after trap mstatus = 32'h1880; after mret mstatus = 32'h1888 and redirect_pc_o = mepc.
4. RW to 0xF11 -> csr_illegal_o = 1, value unchanged; RS to 0xF11 with wdata 0 -> csr_illegal_o = 0; address 0x7C0 -> illegal, rdata 0.
5. Write mcycle = 32'hFFFF_FFFE, mcycleh = 0 -> two cycles later mcycle = 0, mcycleh = 1; same-cycle trap + RW mscratch -> mscratch unchanged.
6. mie = 32'h80, irq_timer_i = 1, MIE = 0 -> irq_pending_o = 0; set MIE = 1 -> irq_pending_o = 1 the next cycle; mip reads 32'h80.

Source files
------------

// File: rtl/csr_trap_unit_pkg.sv
// Shared constants for the machine-mode CSR/trap unit: addresses, op encodings,
// mstatus/mie/mip bit positions, cause codes and the read-modify-write helper.
package csr_trap_unit_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;
    localparam int IRQ_MTI        = 7;
    localparam int IRQ_MEI        = 11;

    localparam logic [31:0] CAUSE_ILLEGAL_INSN = 32'd2;
    localparam logic [31:0] CAUSE_ECALL_M      = 32'd11;
    localparam logic [31:0] CAUSE_M_TIMER      = 32'h8000_0007;
    localparam logic [31:0] CAUSE_M_EXT        = 32'h8000_000B;

    function automatic logic [31:0] csr_apply(csr_op_e op, logic [31:0] old, logic [31:0] wdata);
        case (op)
            CSR_OP_RW: csr_apply = wdata;
            CSR_OP_RS: csr_apply = old | wdata;
            CSR_OP_RC: csr_apply = old & ~wdata;
            default:   csr_apply = old;
        endcase
    endfunction

endpackage

// File: rtl/csr_trap_unit_counter64.sv
// 64-bit free-running counter; a write to either half replaces that cycle's increment.
module csr_counter64 #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    inc_en,
    input  logic                    wr_lo,
    input  logic                    wr_hi,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [2*DATA_WIDTH-1:0] value
);

    always_ff @(posedge clock) begin
        if (reset)       value <= '0;
        else if (wr_lo)  value[DATA_WIDTH-1:0] <= wdata;
        else if (wr_hi)  value[2*DATA_WIDTH-1:DATA_WIDTH] <= wdata;
        else if (inc_en) value <= value + 1'b1;
    end

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with trap entry/mret sequencing and a registered
// PC redirect back to fetch.
module csr_trap_unit
    import csr_trap_unit_pkg::*;
#(
    parameter int                     DATA_WIDTH    = 32,
    parameter logic [DATA_WIDTH-1:0]  MVENDORID_VAL = 32'h7973_7978,
    parameter logic [DATA_WIDTH-1:0]  MARCHID_VAL   = 32'd23060025,
    parameter logic [DATA_WIDTH-1:0]  MTVEC_RESET   = 32'h0,
    parameter bit                     HAS_COUNTERS  = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  csr_valid_i,
    input  logic [1:0]            csr_op_i,
    input  logic [11:0]           csr_addr_i,
    input  logic [DATA_WIDTH-1:0] csr_wdata_i,
    output logic [DATA_WIDTH-1:0] csr_rdata_o,
    output logic                  csr_illegal_o,
    input  logic                  trap_valid_i,
    input  logic [DATA_WIDTH-1:0] trap_cause_i,
    input  logic [DATA_WIDTH-1:0] trap_pc_i,
    input  logic [DATA_WIDTH-1:0] trap_tval_i,
    input  logic                  mret_i,
    input  logic                  instret_i,
    input  logic                  irq_timer_i,
    input  logic                  irq_ext_i,
    output logic                  irq_pending_o,
    output logic                  redirect_valid_o,
    output logic [DATA_WIDTH-1:0] redirect_pc_o
);

    logic                    st_mie, st_mpie;
    logic [DATA_WIDTH-1:0]   mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
    logic [DATA_WIDTH-1:0]   mstatus_rd, mip_rd, new_val, trap_target;
    logic [2*DATA_WIDTH-1:0] mcycle, minstret;
    logic                    known, read_only, is_write, wr_en;
    csr_op_e                 op;

    assign op = csr_op_e'(csr_op_i);

    // MPP is hardwired to M-mode, so it always reads back 11.
    always_comb begin
        mstatus_rd = '0;
        mstatus_rd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        mstatus_rd[MSTATUS_MPIE] = st_mpie;
        mstatus_rd[MSTATUS_MIE]  = st_mie;
        mip_rd = '0;
        mip_rd[IRQ_MTI] = irq_timer_i;
        mip_rd[IRQ_MEI] = irq_ext_i;
    end

    always_comb begin
        known       = 1'b1;
        read_only   = 1'b0;
        csr_rdata_o = '0;
        case (csr_addr_i)
            CSR_MSTATUS:   csr_rdata_o = mstatus_rd;
            CSR_MIE:       csr_rdata_o = mie_q;
            CSR_MTVEC:     csr_rdata_o = mtvec_q;
            CSR_MSCRATCH:  csr_rdata_o = mscratch_q;
            CSR_MEPC:      csr_rdata_o = mepc_q;
            CSR_MCAUSE:    csr_rdata_o = mcause_q;
            CSR_MTVAL:     csr_rdata_o = mtval_q;
            CSR_MIP:       begin csr_rdata_o = mip_rd;        read_only = 1'b1; end
            CSR_MVENDORID: begin csr_rdata_o = MVENDORID_VAL; read_only = 1'b1; end
            CSR_MARCHID:   begin csr_rdata_o = MARCHID_VAL;   read_only = 1'b1; end
            CSR_MCYCLE:    begin csr_rdata_o = mcycle[DATA_WIDTH-1:0];              known = HAS_COUNTERS; end
            CSR_MCYCLEH:   begin csr_rdata_o = mcycle[2*DATA_WIDTH-1:DATA_WIDTH];   known = HAS_COUNTERS; end
            CSR_MINSTRET:  begin csr_rdata_o = minstret[DATA_WIDTH-1:0];            known = HAS_COUNTERS; end
            CSR_MINSTRETH: begin csr_rdata_o = minstret[2*DATA_WIDTH-1:DATA_WIDTH]; known = HAS_COUNTERS; end
            default:       known = 1'b0;
        endcase
        if (!known) csr_rdata_o = '0;
    end

    // RS/RC with a zero operand is a pure read and must never fault on read-only CSRs.
    assign is_write      = (op == CSR_OP_RW) ||
                           ((op == CSR_OP_RS || op == CSR_OP_RC) && (csr_wdata_i != '0));
    assign csr_illegal_o = csr_valid_i & (~known | (read_only & is_write));
    assign wr_en         = csr_valid_i & ~csr_illegal_o & is_write & ~trap_valid_i & ~mret_i;
    assign new_val       = csr_apply(op, csr_rdata_o, csr_wdata_i);

    assign trap_target = {mtvec_q[DATA_WIDTH-1:2], 2'b00} +
                         ((mtvec_q[1:0] == 2'b01 && trap_cause_i[DATA_WIDTH-1])
                              ? {trap_cause_i[DATA_WIDTH-3:0], 2'b00} : '0);

    assign irq_pending_o = st_mie & |(mie_q & mip_rd);

    always_ff @(posedge clock) begin
        if (reset) begin
            st_mie           <= 1'b0;
            st_mpie          <= 1'b0;
            mie_q            <= '0;
            mtvec_q          <= MTVEC_RESET;
            mscratch_q       <= '0;
            mepc_q           <= '0;
            mcause_q         <= '0;
            mtval_q          <= '0;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
        end else begin
            redirect_valid_o <= trap_valid_i | mret_i;
            if (trap_valid_i) begin
                mepc_q        <= {trap_pc_i[DATA_WIDTH-1:2], 2'b00};
                mcause_q      <= trap_cause_i;
                mtval_q       <= trap_tval_i;
                st_mpie       <= st_mie;
                st_mie        <= 1'b0;
                redirect_pc_o <= trap_target;
            end else if (mret_i) begin
                st_mie        <= st_mpie;
                st_mpie       <= 1'b1;
                redirect_pc_o <= mepc_q;
            end else if (wr_en) begin
                case (csr_addr_i)
                    CSR_MSTATUS: begin
                        st_mie  <= new_val[MSTATUS_MIE];
                        st_mpie <= new_val[MSTATUS_MPIE];
                    end
                    CSR_MIE: begin
                        mie_q          <= '0;
                        mie_q[IRQ_MTI] <= new_val[IRQ_MTI];
                        mie_q[IRQ_MEI] <= new_val[IRQ_MEI];
                    end
                    // Reserved modes 1x fall back to direct.
                    CSR_MTVEC:    mtvec_q    <= new_val[1] ? {new_val[DATA_WIDTH-1:2], 2'b00} : new_val;
                    CSR_MSCRATCH: mscratch_q <= new_val;
                    CSR_MEPC:     mepc_q     <= new_val;
                    CSR_MCAUSE:   mcause_q   <= new_val;
                    CSR_MTVAL:    mtval_q    <= new_val;
                    default: ;
                endcase
            end
        end
    end

    generate
        if (HAS_COUNTERS) begin : g_counters
            csr_counter64 #(.DATA_WIDTH(DATA_WIDTH)) u_mcycle (
                .clock (clock),
                .reset (reset),
                .inc_en(1'b1),
                .wr_lo (wr_en && csr_addr_i == CSR_MCYCLE),
                .wr_hi (wr_en && csr_addr_i == CSR_MCYCLEH),
                .wdata (new_val),
                .value (mcycle)
            );
            csr_counter64 #(.DATA_WIDTH(DATA_WIDTH)) u_minstret (
                .clock (clock),
                .reset (reset),
                .inc_en(instret_i),
                .wr_lo (wr_en && csr_addr_i == CSR_MINSTRET),
                .wr_hi (wr_en && csr_addr_i == CSR_MINSTRETH),
                .wdata (new_val),
                .value (minstret)
            );
        end else begin : g_no_counters
            logic unused_instret;
            assign unused_instret = instret_i;
            assign mcycle   = '0;
            assign minstret = '0;
        end
    endgenerate

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed bench for csr_trap_unit: a table of single-cycle CSR accesses
// followed by hand-written trap, mret, counter and interrupt sequences.
module tb_csr_trap_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        csr_valid_i;
    logic [1:0]  csr_op_i;
    logic [11:0] csr_addr_i;
    logic [31:0] csr_wdata_i, csr_rdata_o;
    logic        csr_illegal_o;
    logic        trap_valid_i;
    logic [31:0] trap_cause_i, trap_pc_i, trap_tval_i;
    logic        mret_i, instret_i, irq_timer_i, irq_ext_i, irq_pending_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [1:0] RW = 2'b01, RS = 2'b10, RC = 2'b11;

    typedef struct {
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        ill;
    } vec_t;

    vec_t vecs[21];

    always #5 clock = ~clock;

    csr_trap_unit dut (
        .clock(clock), .reset(reset),
        .csr_valid_i(csr_valid_i), .csr_op_i(csr_op_i), .csr_addr_i(csr_addr_i),
        .csr_wdata_i(csr_wdata_i), .csr_rdata_o(csr_rdata_o), .csr_illegal_o(csr_illegal_o),
        .trap_valid_i(trap_valid_i), .trap_cause_i(trap_cause_i), .trap_pc_i(trap_pc_i),
        .trap_tval_i(trap_tval_i), .mret_i(mret_i), .instret_i(instret_i),
        .irq_timer_i(irq_timer_i), .irq_ext_i(irq_ext_i), .irq_pending_o(irq_pending_o),
        .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic csr(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wdata);
        csr_valid_i = 1'b1;
        csr_op_i    = op;
        csr_addr_i  = addr;
        csr_wdata_i = wdata;
    endtask

    task automatic idle();
        csr_valid_i  = 1'b0;
        csr_op_i     = 2'b00;
        csr_addr_i   = 12'h0;
        csr_wdata_i  = 32'h0;
        trap_valid_i = 1'b0;
        mret_i       = 1'b0;
    endtask

    // Read a CSR combinationally in the current cycle, then advance one clock.
    task automatic read_chk(input string name, input logic [11:0] addr, input logic [31:0] exp);
        csr(RS, addr, 32'h0);
        #1;
        check(name, csr_rdata_o, exp);
        tick();
        idle();
    endtask

    initial begin
        vecs[0]  = '{RS, 12'h300, 32'h0,         32'h0000_1800, 1'b0};
        vecs[1]  = '{RS, 12'hF11, 32'h0,         32'h7973_7978, 1'b0};
        vecs[2]  = '{RS, 12'hF12, 32'h0,         32'd23060025,  1'b0};
        vecs[3]  = '{RW, 12'hF11, 32'h5,         32'h7973_7978, 1'b1};
        vecs[4]  = '{RS, 12'hF11, 32'h0,         32'h7973_7978, 1'b0};
        vecs[5]  = '{RS, 12'h7C0, 32'h0,         32'h0,         1'b1};
        vecs[6]  = '{RW, 12'h340, 32'hDEAD_BEEF, 32'h0,         1'b0};
        vecs[7]  = '{RC, 12'h340, 32'h0000_FFFF, 32'hDEAD_BEEF, 1'b0};
        vecs[8]  = '{RS, 12'h340, 32'h1,         32'hDEAD_0000, 1'b0};
        vecs[9]  = '{RS, 12'h340, 32'h0,         32'hDEAD_0001, 1'b0};
        vecs[10] = '{RW, 12'h304, 32'hFFFF_FFFF, 32'h0,         1'b0};
        vecs[11] = '{RS, 12'h304, 32'h0,         32'h0000_0880, 1'b0};
        vecs[12] = '{RW, 12'h305, 32'h0000_1003, 32'h0,         1'b0};
        vecs[13] = '{RS, 12'h305, 32'h0,         32'h0000_1000, 1'b0};
        vecs[14] = '{RW, 12'h300, 32'hFFFF_FFFF, 32'h0000_1800, 1'b0};
        vecs[15] = '{RS, 12'h300, 32'h0,         32'h0000_1888, 1'b0};
        vecs[16] = '{RC, 12'h300, 32'h0000_0088, 32'h0000_1888, 1'b0};
        vecs[17] = '{RS, 12'h300, 32'h0,         32'h0000_1800, 1'b0};
        vecs[18] = '{RW, 12'h344, 32'h1,         32'h0,         1'b1};
        vecs[19] = '{RC, 12'h344, 32'h0,         32'h0,         1'b0};
        vecs[20] = '{RW, 12'h304, 32'h0,         32'h0000_0880, 1'b0};

        reset = 1'b1;
        idle();
        trap_cause_i = 32'h0; trap_pc_i = 32'h0; trap_tval_i = 32'h0;
        instret_i = 1'b0; irq_timer_i = 1'b0; irq_ext_i = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("reset_redirect_valid", {31'b0, redirect_valid_o}, 32'h0);
        check("reset_redirect_pc", redirect_pc_o, 32'h0);

        foreach (vecs[i]) begin
            csr(vecs[i].op, vecs[i].addr, vecs[i].wdata);
            #1;
            check($sformatf("vec%0d_rdata", i), csr_rdata_o, vecs[i].rdata);
            check($sformatf("vec%0d_illegal", i), {31'b0, csr_illegal_o}, {31'b0, vecs[i].ill});
            tick();
            idle();
        end

        // Vectored interrupt trap; concurrent mscratch write must be dropped.
        csr(RW, 12'h305, 32'h8000_0101);
        tick();
        csr(RW, 12'h340, 32'h1111_1111);
        trap_valid_i = 1'b1;
        trap_cause_i = 32'h8000_0007;
        trap_pc_i    = 32'h8000_0042;
        trap_tval_i  = 32'h0000_1234;
        tick();
        idle();
        check("trap_redirect_valid", {31'b0, redirect_valid_o}, 32'h1);
        check("trap_redirect_pc", redirect_pc_o, 32'h8000_011C);
        read_chk("trap_mepc", 12'h341, 32'h8000_0040);
        check("trap_pulse_low", {31'b0, redirect_valid_o}, 32'h0);
        check("trap_pc_held", redirect_pc_o, 32'h8000_011C);
        read_chk("trap_mcause", 12'h342, 32'h8000_0007);
        read_chk("trap_mtval", 12'h343, 32'h0000_1234);
        read_chk("trap_mscratch_kept", 12'h340, 32'hDEAD_0001);

        // MIE stacking across an exception and mret; same-cycle mepc write dropped.
        csr(RS, 12'h300, 32'h8);
        tick();
        idle();
        trap_valid_i = 1'b1;
        trap_cause_i = 32'd11;
        trap_pc_i    = 32'h0000_0100;
        tick();
        idle();
        check("ecall_redirect_pc", redirect_pc_o, 32'h8000_0100);
        read_chk("trap_mstatus", 12'h300, 32'h0000_1880);
        csr(RW, 12'h341, 32'h0000_0999);
        mret_i = 1'b1;
        tick();
        idle();
        check("mret_redirect_valid", {31'b0, redirect_valid_o}, 32'h1);
        check("mret_redirect_pc", redirect_pc_o, 32'h0000_0100);
        read_chk("mret_mstatus", 12'h300, 32'h0000_1888);
        read_chk("mret_mepc_kept", 12'h341, 32'h0000_0100);

        // mcycle carry from low into high half.
        csr(RW, 12'hB00, 32'hFFFF_FFFE);
        tick();
        csr(RW, 12'hB80, 32'h0);
        tick();
        idle();
        tick();
        tick();
        read_chk("mcycle_lo_wrap", 12'hB00, 32'h0);
        read_chk("mcycle_hi_carry", 12'hB80, 32'h1);

        // minstret: write overrides the retire increment, then counts retires only.
        csr(RW, 12'hB02, 32'h5);
        instret_i = 1'b1;
        tick();
        idle();
        tick();
        tick();
        tick();
        instret_i = 1'b0;
        read_chk("minstret_count", 12'hB02, 32'h8);

        // Interrupt gating by mie and mstatus.MIE.
        csr(RW, 12'h304, 32'h80);
        tick();
        irq_timer_i = 1'b1;
        csr(RC, 12'h300, 32'h8);
        tick();
        idle();
        #1;
        check("irq_masked_by_mie", {31'b0, irq_pending_o}, 32'h0);
        read_chk("mip_timer", 12'h344, 32'h80);
        csr(RS, 12'h300, 32'h8);
        tick();
        idle();
        #1;
        check("irq_pending_timer", {31'b0, irq_pending_o}, 32'h1);
        irq_timer_i = 1'b0;
        irq_ext_i   = 1'b1;
        #1;
        check("irq_ext_not_enabled", {31'b0, irq_pending_o}, 32'h0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
